// File: rtl/rom_access_arbiter.sv
// rom_access_arbiter: two-requester read arbiter in front of a synchronous ROM.
// Round-robin by default; define ROM_ARB_FIXED_PRIO_EN to give requester 0 fixed priority.
module rom_access_arbiter #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 8,
  parameter int ROM_LATENCY = 1
) (
  input  logic                  in_clk,
  input  logic                  in_rst,
  input  logic                  in_req0,
  input  logic                  in_req1,
  input  logic [ADDR_WIDTH-1:0] in_addr0,
  input  logic [ADDR_WIDTH-1:0] in_addr1,
  output logic                  out_ack0,
  output logic                  out_ack1,
  output logic [DATA_WIDTH-1:0] out_data0,
  output logic [DATA_WIDTH-1:0] out_data1,
  output logic                  out_valid0,
  output logic                  out_valid1,
  output logic [ADDR_WIDTH-1:0] out_rom_addr,
  input  logic [DATA_WIDTH-1:0] in_rom_data,
  output logic                  out_busy
);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic owner_q, owner_d;
  logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
  logic [DATA_WIDTH-1:0] data0_q, data0_d, data1_q, data1_d;
  logic ack0_q, ack0_d, ack1_q, ack1_d;
  logic valid0_q, valid0_d, valid1_q, valid1_d;
  logic win1, grant, done;
`ifdef ROM_ARB_FIXED_PRIO_EN
  assign win1 = in_req1 & ~in_req0;
`else
  logic last_q, last_d;
  // last_q = 1 means requester 1 was granted last, so requester 0 wins a tie
  assign win1 = in_req1 & (~in_req0 | ~last_q);
`endif
  assign grant = (state_q == IDLE) & (in_req0 | in_req1);
  assign done  = (state_q == WAIT) & (cnt_q == 4'(ROM_LATENCY));
  always_comb begin
    state_d    = grant ? WAIT : done ? IDLE : state_q;
    cnt_d      = grant ? 4'd0 : (state_q == WAIT && !done) ? cnt_q + 4'd1 : cnt_q;
    owner_d    = grant ? win1 : owner_q;
    rom_addr_d = grant ? (win1 ? in_addr1 : in_addr0) : rom_addr_q;
    ack0_d     = grant & ~win1;
    ack1_d     = grant & win1;
    valid0_d   = done & ~owner_q;
    valid1_d   = done & owner_q;
    data0_d    = valid0_d ? in_rom_data : data0_q;
    data1_d    = valid1_d ? in_rom_data : data1_q;
`ifndef ROM_ARB_FIXED_PRIO_EN
    last_d     = grant ? win1 : last_q;
`endif
  end
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      owner_q    <= 1'b0;
      rom_addr_q <= '0;
      data0_q    <= '0;
      data1_q    <= '0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      valid0_q   <= 1'b0;
      valid1_q   <= 1'b0;
`ifndef ROM_ARB_FIXED_PRIO_EN
      last_q     <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      owner_q    <= owner_d;
      rom_addr_q <= rom_addr_d;
      data0_q    <= data0_d;
      data1_q    <= data1_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
      valid0_q   <= valid0_d;
      valid1_q   <= valid1_d;
`ifndef ROM_ARB_FIXED_PRIO_EN
      last_q     <= last_d;
`endif
    end
  end
  assign out_ack0     = ack0_q;
  assign out_ack1     = ack1_q;
  assign out_valid0   = valid0_q;
  assign out_valid1   = valid1_q;
  assign out_data0    = data0_q;
  assign out_data1    = data1_q;
  assign out_rom_addr = rom_addr_q;
  assign out_busy     = (state_q == WAIT);
endmodule

// File: tb/tb_rom_access_arbiter.sv
// tb_rom_access_arbiter: two arbiter instances (ROM latency 1 and 4) checked against a cycle-level model.
module tb_rom_access_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic        req0 [2], req1 [2], ack0 [2], ack1 [2], valid0 [2], valid1 [2], busy [2];
  logic [15:0] addr0 [2], addr1 [2], rom_addr [2];
  logic [7:0]  rom_data [2], data0 [2], data1 [2];
  logic [7:0]  rom_q;
  logic [7:0]  pipe [4];
  int total = 0;
  int bad = 0;

  function automatic logic [7:0] rom(input logic [15:0] a);
    return (a == 16'h0010) ? 8'hA5 : (a[7:0] * 8'd29) ^ a[15:8] ^ 8'h3C;
  endfunction

  always @(posedge clk) begin
    rom_q   <= rom(rom_addr[0]);
    pipe[0] <= rom(rom_addr[1]);
    for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
  end
  assign rom_data[0] = rom_q;
  assign rom_data[1] = pipe[3];

  rom_access_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .ROM_LATENCY(1)) u_lat1 (
    .in_clk(clk), .in_rst(rst), .in_req0(req0[0]), .in_req1(req1[0]),
    .in_addr0(addr0[0]), .in_addr1(addr1[0]), .out_ack0(ack0[0]), .out_ack1(ack1[0]),
    .out_data0(data0[0]), .out_data1(data1[0]), .out_valid0(valid0[0]), .out_valid1(valid1[0]),
    .out_rom_addr(rom_addr[0]), .in_rom_data(rom_data[0]), .out_busy(busy[0]));

  rom_access_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .ROM_LATENCY(4)) u_lat4 (
    .in_clk(clk), .in_rst(rst), .in_req0(req0[1]), .in_req1(req1[1]),
    .in_addr0(addr0[1]), .in_addr1(addr1[1]), .out_ack0(ack0[1]), .out_ack1(ack1[1]),
    .out_data0(data0[1]), .out_data1(data1[1]), .out_valid0(valid0[1]), .out_valid1(valid1[1]),
    .out_rom_addr(rom_addr[1]), .in_rom_data(rom_data[1]), .out_busy(busy[1]));

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req0[i] = 1'b0; req1[i] = 1'b0; addr0[i] = '0; addr1[i] = '0;
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      total++;
      if ({ack0[i], ack1[i], valid0[i], valid1[i], busy[i], rom_addr[i], data0[i], data1[i]} !== '0) begin
        bad++;
        $display("FAIL reset inst=%0d ack=%b%b valid=%b%b busy=%b addr=%h data=%h/%h expected all 0",
                 i, ack0[i], ack1[i], valid0[i], valid1[i], busy[i], rom_addr[i], data0[i], data1[i]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_read();
    do_reset();
    addr0[0] = 16'h0010; req0[0] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); @(negedge clk);
      total++;
      if (ack0[0] !== (c == 0) || ack1[0] !== 1'b0 || busy[0] !== (c < 2) || valid0[0] !== (c == 2) ||
          rom_addr[0] !== 16'h0010) begin
        bad++;
        $display("FAIL single_read cycle=%0d ack0=%b busy=%b valid0=%b addr=%h expected ack0=%b busy=%b valid0=%b addr=0010",
                 c + 1, ack0[0], busy[0], valid0[0], rom_addr[0], c == 0, c < 2, c == 2);
      end
      if (ack0[0]) req0[0] = 1'b0;
    end
    total++;
    if (data0[0] !== 8'hA5) begin
      bad++;
      $display("FAIL single_read_data got=%h expected=a5", data0[0]);
    end
  endtask

  task automatic test_tie();
    do_reset();
    addr0[0] = 16'h0001; addr1[0] = 16'h0002; req0[0] = 1'b1; req1[0] = 1'b1;
    for (int c = 0; c < 7; c++) begin
      @(posedge clk); @(negedge clk);
      total++;
      if (ack0[0] !== (c == 0) || ack1[0] !== (c == 3) || valid0[0] !== (c == 2) || valid1[0] !== (c == 5)) begin
        bad++;
        $display("FAIL tie edge=%0d ack=%b%b valid=%b%b expected ack=%b%b valid=%b%b",
                 c, ack0[0], ack1[0], valid0[0], valid1[0], c == 0, c == 3, c == 2, c == 5);
      end
      if (ack0[0]) req0[0] = 1'b0;
      if (ack1[0]) req1[0] = 1'b0;
    end
    total++;
    if (data0[0] !== rom(16'h0001) || data1[0] !== rom(16'h0002)) begin
      bad++;
      $display("FAIL tie_data got=%h/%h expected=%h/%h", data0[0], data1[0], rom(16'h0001), rom(16'h0002));
    end
  endtask

  task automatic test_fairness();
    int n = 0;
    int v1 = 0;
    logic exp_w;
    do_reset();
    addr0[0] = 16'h00AA; addr1[0] = 16'h00BB; req0[0] = 1'b1; req1[0] = 1'b1;
    for (int c = 0; c < 40 && n < 6; c++) begin
      @(posedge clk); @(negedge clk);
      if (valid1[0]) v1++;
      if (ack0[0] || ack1[0]) begin
`ifdef ROM_ARB_FIXED_PRIO_EN
        exp_w = 1'b0;
`else
        exp_w = n[0];
`endif
        total++;
        if ((ack0[0] && ack1[0]) || ack1[0] !== exp_w) begin
          bad++;
          $display("FAIL fairness grant=%0d ack=%b%b expected winner=%0d", n, ack0[0], ack1[0], exp_w);
        end
        n++;
      end
    end
    total++;
    if (n != 6) begin
      bad++;
      $display("FAIL fairness_count grants=%0d expected=6", n);
    end
`ifdef ROM_ARB_FIXED_PRIO_EN
    total++;
    if (v1 != 0) begin
      bad++;
      $display("FAIL starvation valid1_pulses=%0d expected=0", v1);
    end
`endif
    req0[0] = 1'b0; req1[0] = 1'b0;
  endtask

  task automatic test_latency_sweep();
    logic [15:0] a;
    logic r;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      a = (k == 0) ? 16'h0000 : (k == 1) ? 16'h7FFF : 16'hFFFF;
      r = k[0];
      if (r) begin addr1[1] = a; req1[1] = 1'b1; end
      else begin addr0[1] = a; req0[1] = 1'b1; end
      for (int c = 0; c < 6; c++) begin
        @(posedge clk); @(negedge clk);
        total++;
        if ((r ? ack1[1] : ack0[1]) !== (c == 0) || (r ? valid1[1] : valid0[1]) !== (c == 5) ||
            busy[1] !== (c < 5) || rom_addr[1] !== a) begin
          bad++;
          $display("FAIL latency addr=%h cycle=%0d ack=%b valid=%b busy=%b rom_addr=%h expected ack=%b valid=%b busy=%b",
                   a, c + 1, r ? ack1[1] : ack0[1], r ? valid1[1] : valid0[1], busy[1], rom_addr[1], c == 0, c == 5, c < 5);
        end
        if (c == 0) begin req0[1] = 1'b0; req1[1] = 1'b0; end
      end
      total++;
      if ((r ? data1[1] : data0[1]) !== rom(a)) begin
        bad++;
        $display("FAIL latency_data addr=%h got=%h expected=%h", a, r ? data1[1] : data0[1], rom(a));
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    addr0[1] = 16'h1234; req0[1] = 1'b1;
    @(posedge clk); @(negedge clk);
    req0[1] = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    total++;
    if ({ack0[1], ack1[1], valid0[1], valid1[1], busy[1], rom_addr[1], data0[1], data1[1]} !== '0) begin
      bad++;
      $display("FAIL reset_mid busy=%b addr=%h data=%h/%h expected all 0", busy[1], rom_addr[1], data0[1], data1[1]);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); @(negedge clk);
      total++;
      if (valid0[1] !== 1'b0 || valid1[1] !== 1'b0 || busy[1] !== 1'b0) begin
        bad++;
        $display("FAIL reset_abort cycle=%0d valid=%b%b busy=%b expected 000", c, valid0[1], valid1[1], busy[1]);
      end
    end
    addr1[1] = 16'h4321; req1[1] = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); @(negedge clk);
      total++;
      if (ack1[1] !== (c == 0) || valid1[1] !== (c == 5) || valid0[1] !== 1'b0) begin
        bad++;
        $display("FAIL reset_after cycle=%0d ack1=%b valid=%b%b expected ack1=%b valid1=%b", c + 1, ack1[1],
                 valid0[1], valid1[1], c == 0, c == 5);
      end
      if (ack1[1]) req1[1] = 1'b0;
    end
    total++;
    if (data1[1] !== rom(16'h4321) || data0[1] !== 8'h00) begin
      bad++;
      $display("FAIL reset_after_data got=%h/%h expected=00/%h", data0[1], data1[1], rom(16'h4321));
    end
  endtask

  task automatic test_late_arrival();
    do_reset();
    addr0[0] = 16'h0100; req0[0] = 1'b1;
    for (int c = 0; c < 7; c++) begin
      @(posedge clk); @(negedge clk);
      total++;
      if (ack0[0] !== (c == 0) || ack1[0] !== (c == 3) || valid0[0] !== (c == 2) || valid1[0] !== (c == 5) ||
          (c >= 2 && data0[0] !== rom(16'h0100))) begin
        bad++;
        $display("FAIL late_arrival edge=%0d ack=%b%b valid=%b%b data0=%h expected ack=%b%b valid=%b%b",
                 c, ack0[0], ack1[0], valid0[0], valid1[0], data0[0], c == 0, c == 3, c == 2, c == 5);
      end
      if (ack0[0]) req0[0] = 1'b0;
      if (ack1[0]) req1[0] = 1'b0;
      if (c == 1) begin addr1[0] = 16'h0200; req1[0] = 1'b1; end
    end
    total++;
    if (data0[0] !== rom(16'h0100) || data1[0] !== rom(16'h0200)) begin
      bad++;
      $display("FAIL late_arrival_data got=%h/%h expected=%h/%h", data0[0], data1[0], rom(16'h0100), rom(16'h0200));
    end
  endtask

  // Model: a grant happens at any edge where no access is in flight and someone requests;
  // ack follows the grant edge, valid follows edge g+1+lat, and the next grant is allowed from g+2+lat.
  task automatic test_random(input int i, input int lat);
    int g = -100;
    logic own = 1'b0;
    logic last = 1'b1;
    logic [15:0] gaddr = '0;
    logic [15:0] a0, a1;
    logic [7:0] ed0 = '0;
    logic [7:0] ed1 = '0;
    logic r0, r1;
    logic [1:0] eack, eval;
    do_reset();
    for (int e = 0; e < 300; e++) begin
      r0 = req0[i]; r1 = req1[i]; a0 = addr0[i]; a1 = addr1[i];
      @(posedge clk); @(negedge clk);
      if (e > g + 1 + lat && (r0 || r1)) begin
`ifdef ROM_ARB_FIXED_PRIO_EN
        own = !r0;
`else
        own = (r0 && r1) ? !last : r1;
`endif
        last = own; g = e; gaddr = own ? a1 : a0;
      end
      if (e == g + 1 + lat) begin
        if (own) ed1 = rom(gaddr); else ed0 = rom(gaddr);
      end
      eack = (e == g) ? (own ? 2'b10 : 2'b01) : 2'b00;
      eval = (e == g + 1 + lat) ? (own ? 2'b10 : 2'b01) : 2'b00;
      total++;
      if ({ack1[i], ack0[i]} !== eack || {valid1[i], valid0[i]} !== eval || busy[i] !== (e >= g && e <= g + lat) ||
          rom_addr[i] !== gaddr || data0[i] !== ed0 || data1[i] !== ed1) begin
        bad++;
        $display("FAIL random inst=%0d edge=%0d ack=%b%b valid=%b%b busy=%b addr=%h data=%h/%h expected ack=%b valid=%b busy=%b addr=%h data=%h/%h",
                 i, e, ack1[i], ack0[i], valid1[i], valid0[i], busy[i], rom_addr[i], data0[i], data1[i],
                 eack, eval, e >= g && e <= g + lat, gaddr, ed0, ed1);
      end
      if (ack0[i]) req0[i] = 1'b0;
      else if (!req0[i] && $urandom_range(0, 2) == 0) begin req0[i] = 1'b1; addr0[i] = 16'($urandom); end
      if (ack1[i]) req1[i] = 1'b0;
      else if (!req1[i] && $urandom_range(0, 2) == 0) begin req1[i] = 1'b1; addr1[i] = 16'($urandom); end
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      req0[i] = 1'b0; req1[i] = 1'b0; addr0[i] = '0; addr1[i] = '0;
    end
    test_reset();
    test_single_read();
    test_tie();
    test_fairness();
    test_latency_sweep();
    test_reset_mid();
    test_late_arrival();
    test_random(0, 1);
    test_random(1, 4);
    test_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rom_access_arbiter.md
ROM_ACCESS_ARBITER -- requirements
Module: rom_access_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 16, ROM address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8, ROM data width.
REQ-003 The block SHALL have parameter ROM_LATENCY, default 1, legal 1..8: edges from out_rom_addr change to valid in_rom_data.
REQ-004 The block SHALL have port in_clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port in_rst, input, 1, reset, asynchronous and active-high.
REQ-006 The block SHALL have ports in_req0 and in_req1, input, 1 each, level read requests from requesters 0 and 1.
REQ-007 The block SHALL have ports in_addr0 and in_addr1, input, ADDR_WIDTH each, read address, stable while the matching in_reqN is high.
REQ-008 The block SHALL have ports out_ack0 and out_ack1, output, 1 each, one-cycle grant pulses.
REQ-009 The block SHALL have ports out_data0 and out_data1, output, DATA_WIDTH each, registered read data.
REQ-010 The block SHALL have ports out_valid0 and out_valid1, output, 1 each, one-cycle pulses marking out_dataN valid.
REQ-011 The block SHALL have port out_rom_addr, output, ADDR_WIDTH, address to the synchronous ROM.
REQ-012 The block SHALL have port in_rom_data, input, DATA_WIDTH, data from the ROM.
REQ-013 The block SHALL have port out_busy, output, 1, high whenever the FSM is not in IDLE.

Function
REQ-014 The FSM SHALL have two states: IDLE and WAIT; a latency counter (4 bits) and a grant-owner bit SHALL accompany it.
REQ-015 In IDLE, requests SHALL be sampled only there; with no request, the FSM SHALL stay in IDLE and all outputs SHALL hold.
REQ-016 On the IDLE edge with a winner N (edge k), the block SHALL set out_rom_addr to in_addrN, pulse out_ackN high for the following cycle, clear the counter, record owner N, and go to WAIT.
REQ-017 In WAIT, at each edge: if counter equals ROM_LATENCY, the block SHALL load out_dataN from in_rom_data, pulse out_validN for one cycle, and go to IDLE; otherwise it SHALL increment the counter.
REQ-018 The first edge in WAIT SHALL only increment the counter, giving out_validN high in the cycle after edge k+1+ROM_LATENCY; the next grant SHALL occur no earlier than edge k+2+ROM_LATENCY.
REQ-019 A requester SHALL deassert in_reqN after observing out_ackN; a request still high in IDLE SHALL be a new access.
REQ-020 Round-robin arbitration (default): on simultaneous requests, the requester not granted last SHALL win; with a single request, that requester SHALL win regardless of history.
REQ-021 A request arriving while busy SHALL wait without loss and be served at the next IDLE edge.
REQ-022 out_rom_addr and out_dataN SHALL hold their last values between accesses; out_dataN of the non-owner SHALL never change.
REQ-023 out_ack0 and out_ack1 SHALL never both be high; out_valid0 and out_valid1 SHALL never both be high.

Reset
REQ-024 Reset SHALL immediately force IDLE, counter 0, last-granted = 1 (requester 0 wins the first tie), out_rom_addr 0, out_data0/1 0, out_ack0/1 0, out_valid0/1 0, and out_busy 0.
REQ-025 Reset during WAIT SHALL abort the access with no out_validN pulse; requesters SHALL re-request.

Configuration
REQ-026 The macro ROM_ARB_FIXED_PRIO_EN SHALL select the arbitration policy.
REQ-027 With ROM_ARB_FIXED_PRIO_EN defined, requester 0 SHALL always win simultaneous requests, and the last-granted bit SHALL be absent.
REQ-028 Without ROM_ARB_FIXED_PRIO_EN, the round-robin arbitration of REQ-020 SHALL apply.

Verification
REQ-029 Single read, ROM_LATENCY=1: in_req0=1, in_addr0=0x0010 at edge 0 (ROM[0x0010]=0xA5) -> out_ack0 high in cycle 1, out_rom_addr=0x0010, out_valid0 high in cycle 3, out_data0=0xA5, out_busy high cycles 1-2.
REQ-030 Tie after reset: both requesters high with addr0=0x0001, addr1=0x0002 -> requester 0 served first, requester 1 granted at edge 3; out_data1=ROM[0x0002].
REQ-031 Round-robin fairness: both requesters held continuously for 6 accesses -> grants alternate 0,1,0,1,0,1; with ROM_ARB_FIXED_PRIO_EN and requester 0 always re-requesting -> requester 1 starves, no valid1 pulse.
REQ-032 Latency sweep with ROM_LATENCY=4: ack at cycle 1, out_valid high in cycle 6; data matches ROM at every address 0x0000, 0x7FFF, and 0xFFFF.
REQ-033 Reset mid-access: assert in_rst in cycle 2 of a ROM_LATENCY=4 read -> no out_validN pulse, all outputs 0, the next request is served normally.
REQ-034 Late arrival: in_req1 rises while busy serving requester 0 -> requester 1 is granted at the first IDLE edge, out_data0 is unchanged afterwards.
